// File: rtl/quant_pkg.sv
// quant_pkg: JPEG quantization tables, their 16-bit reciprocals and the FSM states.
package quant_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [7:0] LUMA_Q [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};
  localparam logic [7:0] CHROMA_Q [64] = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99};
  // round(65536/Q[k])
  localparam logic [15:0] LUMA_RECIP [64] = '{
    16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
    16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
    16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950, 16'd1170,
    16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753, 16'd819, 16'd1057,
    16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964, 16'd601, 16'd636, 16'd851,
    16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809, 16'd630, 16'd580, 16'd712,
    16'd1337, 16'd1024, 16'd840, 16'd753, 16'd636, 16'd542, 16'd546, 16'd649,
    16'd910, 16'd712, 16'd690, 16'd669, 16'd585, 16'd655, 16'd636, 16'd662};
  localparam logic [15:0] CHROMA_RECIP [64] = '{
    16'd3855, 16'd3641, 16'd2731, 16'd1394, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd3641, 16'd3121, 16'd2521, 16'd993, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd2731, 16'd2521, 16'd1170, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd1394, 16'd993, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662,
    16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662, 16'd662};
endpackage

// File: rtl/quant_lane.sv
// quant_lane: combinational coef*recip quantizer with saturation (coef, recip, q_shift -> result); QUANT_ROUND_EN selects round-half-away vs truncate.
module quant_lane #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  coef,
  input  logic        [15:0]      recip,
  input  logic        [1:0]       q_shift,
  output logic signed [OUT_W-1:0] result
);
  localparam int PW = IN_W + 16;
  localparam logic [PW-1:0] MAXP = PW'((1 << (OUT_W - 1)) - 1);
  localparam logic [PW-1:0] MAXN = PW'(1 << (OUT_W - 1));
  logic neg;
  logic [IN_W-1:0] m;
  logic [PW-1:0] p, r;
  assign neg = coef[IN_W-1];
  // unsigned negate so the most negative code maps to magnitude 2^(IN_W-1)
  assign m = neg ? ~coef + 1'b1 : coef;
  assign p = PW'(m) * PW'(recip);
`ifdef QUANT_ROUND_EN
  assign r = (p + (PW'(1) << (15 + q_shift))) >> (16 + q_shift);
`else
  assign r = p >> (16 + q_shift);
`endif
  assign result = neg ? (r >= MAXN ? OUT_W'(MAXN) : OUT_W'(PW'(0) - r))
                      : (r > MAXP ? OUT_W'(MAXP) : OUT_W'(r));
endmodule

// File: rtl/quant_block_pipe.sv
// quant_block_pipe: quantizes an NCH x 64 coefficient block, LANES per channel per cycle; ports clk/reset, in_valid/in_ready/in_data/q_shift, out_valid/out_ready/out_data; QUANT_ROUND_EN enables rounding.
module quant_block_pipe
  import quant_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 10,
  parameter int LANES = 8,
  parameter int NCH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*64*IN_W-1:0]  in_data,
  input  logic [1:0]              q_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*64*OUT_W-1:0] out_data
);
  localparam int N  = 64 / LANES;
  localparam int GW = N > 1 ? $clog2(N) : 1;
  if (64 % LANES != 0 || NCH < 1 || OUT_W > IN_W) begin : g_bad
    $error("quant_block_pipe: illegal LANES/NCH/OUT_W");
  end
  state_t state;
  logic [GW-1:0] g;
  logic [NCH*64*IN_W-1:0] cap;
  logic [1:0] qs;
  logic signed [OUT_W-1:0] res [NCH][LANES];
  assign in_ready = state == IDLE && !reset;
  assign out_valid = state == DONE;
  genvar c, l;
  for (c = 0; c < NCH; c++) begin : g_ch
    for (l = 0; l < LANES; l++) begin : g_lane
      logic [5:0] k;
      assign k = 6'(int'(g) * LANES + l);
      quant_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
        .coef(cap[(c*64+int'(k))*IN_W +: IN_W]),
        .recip(c == 0 ? LUMA_RECIP[k] : CHROMA_RECIP[k]),
        .q_shift(qs),
        .result(res[c][l])
      );
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      out_data <= '0;
      cap <= '0;
      qs <= '0;
    end else if (state == IDLE && in_valid) begin
      state <= RUN;
      cap <= in_data;
      qs <= q_shift;
      g <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCH; i++)
        for (int j = 0; j < LANES; j++)
          out_data[(i*64+int'(g)*LANES+j)*OUT_W +: OUT_W] <= res[i][j];
      g <= g + 1'b1;
      if (g == GW'(N - 1)) state <= DONE;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_quant_block_pipe.sv
// tb_quant_block_pipe: directed and randomized checks of quant_block_pipe at default parameters.
module tb_quant_block_pipe;
  localparam int IN_W = 14, OUT_W = 10, LANES = 8, NCH = 3, N = 64 / LANES;
  localparam int DW = NCH*64*IN_W, OW = NCH*64*OUT_W;
`ifdef QUANT_ROUND_EN
  localparam bit RND = 1;
`else
  localparam bit RND = 0;
`endif
  localparam int LQ [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55,
    14,13,16,24,40,57,69,56, 14,17,22,29,51,87,80,62, 18,22,37,56,68,109,103,77,
    24,35,55,64,81,104,113,92, 49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
  localparam int CQ [64] = '{17,18,24,47,99,99,99,99, 18,21,26,66,99,99,99,99,
    24,26,56,99,99,99,99,99, 47,66,99,99,99,99,99,99, 99,99,99,99,99,99,99,99,
    99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99};
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [1:0] q_shift = 0;
  logic [DW-1:0] in_data = '0;
  logic [OW-1:0] out_data;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  quant_block_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .NCH(NCH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .q_shift(q_shift), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  function automatic int model(int coef, int c, int k, int qs);
    longint q = c == 0 ? LQ[k] : CQ[k];
    longint m = coef < 0 ? -coef : coef;
    longint rc = (65536 + q / 2) / q;
    longint p = m * rc;
    longint r = (p + (RND ? (longint'(1) << (15 + qs)) : 0)) >> (16 + qs);
    longint s = coef < 0 ? -r : r;
    s = s > 511 ? 511 : s < -512 ? -512 : s;
    return int'(s);
  endfunction
  function automatic int cin(logic [DW-1:0] d, int c, int k);
    return int'($signed(d[(c*64+k)*IN_W +: IN_W]));
  endfunction
  function automatic int cout(logic [OW-1:0] d, int c, int k);
    return int'($signed(d[(c*64+k)*OUT_W +: OUT_W]));
  endfunction
  function automatic logic [DW-1:0] put(logic [DW-1:0] d, int c, int k, int v);
    d[(c*64+k)*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction
  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] d = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 64; k++) begin
        int sel = $urandom_range(0, 7);
        d = put(d, c, k, sel == 0 ? -8192 : sel == 1 ? 8191 : sel < 4 ? $urandom_range(0, 400) - 200
                         : $urandom_range(0, 16383) - 8192);
      end
    return d;
  endfunction
  // offer a block (caller at a negedge) and wait for out_valid; leaves us at a negedge
  task automatic xfer(input logic [DW-1:0] d, input logic [1:0] qs, output int lat, output bit tmo);
    int t = 0;
    in_data = d;
    q_shift = qs;
    in_valid = 1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    tmo = t >= 100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_data = ~d;
    q_shift = ~qs;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic drain();
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    vectors++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: out_data nonzero, want 0");
    end
    reset = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask
  task automatic test_quant();
    logic [DW-1:0] d;
    int lat;
    bit tmo;
    int ea [4];
    int ga [4];
    logic [1:0] qs;
    for (int b = 0; b < 3; b++) begin
      d = '0;
      qs = b == 2 ? 2'd2 : 2'd0;
      if (b == 0) begin
        d = put(d, 0, 0, 1000);
        d = put(d, 0, 2, 8191);
        d = put(d, 1, 0, 170);
        d = put(d, 2, 63, -8192);
      end else if (b == 1) begin
        d = put(d, 0, 0, -1000);
        d = put(d, 0, 2, -8192);
      end else d = put(d, 0, 0, 1000);
      xfer(d, qs, lat, tmo);
      vectors++;
      if (tmo || lat !== N) begin
        errors++;
        $display("FAIL quant_latency blk%0d: lat=%0d tmo=%0d want %0d", b, lat, tmo, N);
      end
      ga = '{cout(out_data, 0, 0), cout(out_data, 0, 2), cout(out_data, 1, 0), cout(out_data, 2, 63)};
      if (b == 0) ea = '{RND ? 63 : 62, 511, RND ? 10 : 9, RND ? -83 : -82};
      else if (b == 1) ea = '{RND ? -63 : -62, -512, 0, 0};
      else ea = '{RND ? 16 : 15, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (ga[i] !== ea[i]) begin
          errors++;
          $display("FAIL quant_directed blk%0d item%0d: got %0d want %0d", b, i, ga[i], ea[i]);
        end
      end
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < 64; k++) begin
          vectors++;
          if (cout(out_data, c, k) !== model(cin(d, c, k), c, k, qs)) begin
            errors++;
            $display("FAIL quant_block blk%0d c%0d k%0d: got %0d want %0d", b, c, k,
                     cout(out_data, c, k), model(cin(d, c, k), c, k, qs));
          end
        end
      drain();
    end
  endtask
  task automatic test_handshake();
    logic [DW-1:0] d, d2;
    logic [OW-1:0] snap;
    int lat;
    bit tmo;
    d = rand_block();
    d2 = rand_block();
    xfer(d, 2'd1, lat, tmo);
    vectors++;
    if (tmo || lat !== N) begin
      errors++;
      $display("FAIL hs_latency: lat=%0d tmo=%0d want %0d", lat, tmo, N);
    end
    snap = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) begin
        errors++;
        $display("FAIL hs_hold cyc%0d: out_valid=%b in_ready=%b stable=%0d want 1 0 1", i, out_valid,
                 in_ready, out_data === snap);
      end
    end
    in_data = d2;
    q_shift = 2'd3;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    in_data = '0;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_accept_next: in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    vectors++;
    if (lat !== N) begin
      errors++;
      $display("FAIL hs_latency2: lat=%0d want %0d", lat, N);
    end
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 64; k++) begin
        vectors++;
        if (cout(out_data, c, k) !== model(cin(d2, c, k), c, k, 3)) begin
          errors++;
          $display("FAIL hs_block c%0d k%0d: got %0d want %0d", c, k, cout(out_data, c, k),
                   model(cin(d2, c, k), c, k, 3));
        end
      end
    drain();
  endtask
  task automatic test_reset_mid_run();
    logic [DW-1:0] d;
    int lat;
    bit tmo;
    in_data = rand_block();
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: out_valid=%b data_zero=%0d in_ready=%b want 0 1 0", out_valid,
               out_data === '0, in_ready);
    end
    @(negedge clk);
    reset = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    d = rand_block();
    xfer(d, 2'd0, lat, tmo);
    vectors++;
    if (tmo || lat !== N) begin
      errors++;
      $display("FAIL midrun_latency: lat=%0d tmo=%0d want %0d", lat, tmo, N);
    end
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 64; k++) begin
        vectors++;
        if (cout(out_data, c, k) !== model(cin(d, c, k), c, k, 0)) begin
          errors++;
          $display("FAIL midrun_block c%0d k%0d: got %0d want %0d", c, k, cout(out_data, c, k),
                   model(cin(d, c, k), c, k, 0));
        end
      end
    drain();
  endtask
  task automatic test_random();
    logic [DW-1:0] d;
    logic [1:0] qs;
    int lat;
    bit tmo;
    for (int b = 0; b < 30; b++) begin
      d = rand_block();
      qs = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(d, qs, lat, tmo);
      vectors++;
      if (tmo || lat !== N) begin
        errors++;
        $display("FAIL rand_latency blk%0d: lat=%0d tmo=%0d want %0d", b, lat, tmo, N);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < 64; k++) begin
          vectors++;
          if (cout(out_data, c, k) !== model(cin(d, c, k), c, k, qs)) begin
            errors++;
            $display("FAIL rand_block blk%0d c%0d k%0d: got %0d want %0d", b, c, k,
                     cout(out_data, c, k), model(cin(d, c, k), c, k, qs));
          end
        end
      drain();
    end
  endtask
  initial begin
    test_reset();
    test_quant();
    test_handshake();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
